// File: rtl/gpio_event_controller.sv
// APB LED/key controller: prescaled tick drives LED blinking and key debouncing;
// debounced key presses latch as pending events that raise a level interrupt.
module gpio_event_controller #(
  parameter int CLK_DIV  = 1000,
  parameter int DEBOUNCE = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [2:0]  leds,
  input  logic [1:0]  keys,
  output logic        irq,
  input  logic [3:0]  apb_PADDR,
  input  logic        apb_PSEL,
  input  logic        apb_PENABLE,
  output logic        apb_PREADY,
  input  logic        apb_PWRITE,
  input  logic [31:0] apb_PWDATA,
  output logic [31:0] apb_PRDATA
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE - 1);

  logic [PW-1:0]        presc_r;
  logic                 tick_s;
  logic [2:0]           static_r;
  logic [2:0]           blink_en_r;
  logic [15:0]          half_r;
  logic [1:0]           irq_en_r;
  logic [1:0]           pending_r;
  logic [15:0]          blink_cnt_r;
  logic                 phase_r;
  logic [15:0]          half_m1_s;
  logic [15:0]          blink_cnt_nxt_s;
  logic                 phase_nxt_s;
  logic [1:0]           sync1_r;
  logic [1:0]           sync2_r;
  logic [1:0]           stable_r;
  logic [1:0]           stable_nxt_s;
  logic [1:0][DW-1:0]   db_cnt_r;
  logic [1:0][DW-1:0]   db_cnt_nxt_s;
  logic [1:0]           rise_s;
  logic [1:0]           clr_s;
  logic [1:0]           pending_nxt_s;
  logic                 wr_s;
  logic                 wr_led_s;
  logic                 wr_half_s;
  logic                 wr_key_s;
  logic                 wr_irq_en_s;
  logic                 unused_s;

  assign apb_PREADY  = 1'b1;
  assign unused_s    = ^{apb_PWDATA[31:16], apb_PADDR[1:0]};
  assign tick_s      = (presc_r == PRESC_MAX);
  assign wr_s        = apb_PSEL & apb_PENABLE & apb_PWRITE;
  assign wr_led_s    = wr_s & (apb_PADDR[3:2] == 2'd0);
  assign wr_half_s   = wr_s & (apb_PADDR[3:2] == 2'd1);
  assign wr_key_s    = wr_s & (apb_PADDR[3:2] == 2'd2);
  assign wr_irq_en_s = wr_s & (apb_PADDR[3:2] == 2'd3);

  // Tick prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      static_r   <= 3'b000;
      blink_en_r <= 3'b000;
      half_r     <= 16'd0;
      irq_en_r   <= 2'b00;
    end else begin
      if (wr_led_s) begin
        static_r   <= apb_PWDATA[2:0];
        blink_en_r <= apb_PWDATA[6:4];
      end
      if (wr_half_s) begin
        half_r <= apb_PWDATA[15:0];
      end
      if (wr_irq_en_s) begin
        irq_en_r <= apb_PWDATA[1:0];
      end
    end
  end

  // A half-period of 0 is treated as 1, so the compare threshold floors at 0
  assign half_m1_s = (half_r == 16'd0) ? 16'd0 : (half_r - 16'd1);

  // Blink counter and phase next state; a BLINK_HALF write restarts the period
  always_comb begin
    blink_cnt_nxt_s = blink_cnt_r;
    phase_nxt_s     = phase_r;
    if (wr_half_s) begin
      blink_cnt_nxt_s = 16'd0;
      phase_nxt_s     = 1'b0;
    end else if (tick_s) begin
      if (blink_cnt_r >= half_m1_s) begin
        blink_cnt_nxt_s = 16'd0;
        phase_nxt_s     = ~phase_r;
      end else begin
        blink_cnt_nxt_s = blink_cnt_r + 16'd1;
        phase_nxt_s     = phase_r;
      end
    end else begin
      blink_cnt_nxt_s = blink_cnt_r;
      phase_nxt_s     = phase_r;
    end
  end

  // Blink state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r <= 16'd0;
      phase_r     <= 1'b0;
    end else begin
      blink_cnt_r <= blink_cnt_nxt_s;
      phase_r     <= phase_nxt_s;
    end
  end

  // Key synchronizers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= keys;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next state: accept a change on the DEBOUNCE-th consecutive differing tick
  always_comb begin
    stable_nxt_s = stable_r;
    db_cnt_nxt_s = db_cnt_r;
    for (int k = 0; k < 2; k++) begin
      if (tick_s) begin
        if (sync2_r[k] != stable_r[k]) begin
          if (db_cnt_r[k] == DB_MAX) begin
            stable_nxt_s[k] = sync2_r[k];
            db_cnt_nxt_s[k] = '0;
          end else begin
            stable_nxt_s[k] = stable_r[k];
            db_cnt_nxt_s[k] = db_cnt_r[k] + DW'(1);
          end
        end else begin
          stable_nxt_s[k] = stable_r[k];
          db_cnt_nxt_s[k] = '0;
        end
      end else begin
        stable_nxt_s[k] = stable_r[k];
        db_cnt_nxt_s[k] = db_cnt_r[k];
      end
    end
  end

  // Debounce state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_r <= 2'b00;
      db_cnt_r <= '0;
    end else begin
      stable_r <= stable_nxt_s;
      db_cnt_r <= db_cnt_nxt_s;
    end
  end

  // Rising edges of the debounced level set pending; a simultaneous W1C loses
  assign rise_s        = stable_nxt_s & ~stable_r;
  assign clr_s         = wr_key_s ? apb_PWDATA[9:8] : 2'b00;
  assign pending_nxt_s = (pending_r & ~clr_s) | rise_s;

  // Pending events, LED drive and interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= 2'b00;
      leds      <= 3'b000;
      irq       <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      leds      <= (blink_en_r & {3{phase_r}}) | (~blink_en_r & static_r);
      irq       <= |(pending_r & irq_en_r);
    end
  end

  // Register read mux
  always_comb begin
    apb_PRDATA = 32'd0;
    case (apb_PADDR[3:2])
      2'd0:    apb_PRDATA = {25'd0, blink_en_r, 1'b0, static_r};
      2'd1:    apb_PRDATA = {16'd0, half_r};
      2'd2:    apb_PRDATA = {22'd0, pending_r, 6'd0, stable_r};
      2'd3:    apb_PRDATA = {30'd0, irq_en_r};
      default: apb_PRDATA = 32'd0;
    endcase
  end

endmodule
